// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one req/ack memory port between the instruction prefetcher and the
// execution-unit (XU) data port. Only one memory transaction is in flight at a
// time. Each access goes IDLE -> BUSY -> TURN.
//
// Grant rule: XU wins unless prefetch is also waiting and XU has already
// taken STARVE grants in a row while prefetch waited.
//
// A prefetch flush during a prefetch transaction does not abort the memory
// cycle. The completion is discarded when m_ack arrives.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pf_req_i/pf_adr_i   prefetch request and word address
//   pf_ack_o/pf_dtr_o   prefetch completion pulse and held read data
//   pf_flush_i          discard any outstanding prefetch completion
//   xu_req_i/xu_we_i    XU request and write enable
//   xu_adr_i/xu_dtw_i   XU word address and write data
//   xu_ack_o/xu_dtr_o   XU completion pulse and held read data
//   m_req_o/m_we_o      memory request and write enable
//   m_adr_o/m_dtw_o     memory address and write data
//   m_ack_i/m_dtr_i     memory completion pulse and read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW     = 20,
    parameter int DW     = 16,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pf_req_i,
    input  logic [AW-1:0] pf_adr_i,
    output logic          pf_ack_o,
    output logic [DW-1:0] pf_dtr_o,
    input  logic          pf_flush_i,
    input  logic          xu_req_i,
    input  logic          xu_we_i,
    input  logic [AW-1:0] xu_adr_i,
    input  logic [DW-1:0] xu_dtw_i,
    output logic          xu_ack_o,
    output logic [DW-1:0] xu_dtr_o,
    output logic          m_req_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_adr_o,
    output logic [DW-1:0] m_dtw_o,
    input  logic          m_ack_i,
    input  logic [DW-1:0] m_dtr_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_TURN
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_PF,
        OWN_XU
    } owner_t;

    state_t        state_q,  state_d;
    owner_t        owner_q,  owner_d;
    logic [3:0]    starve_q, starve_d;
    logic          drop_q,   drop_d;
    logic          m_req_q,  m_req_d;
    logic          m_we_q,   m_we_d;
    logic [AW-1:0] m_adr_q,  m_adr_d;
    logic [DW-1:0] m_dtw_q,  m_dtw_d;
    logic          pf_ack_q, pf_ack_d;
    logic          xu_ack_q, xu_ack_d;
    logic [DW-1:0] pf_dtr_q, pf_dtr_d;
    logic [DW-1:0] xu_dtr_q, xu_dtr_d;

    logic grant_xu;

    // XU keeps priority until it has starved a waiting prefetch STARVE times.
    assign grant_xu = xu_req_i && ((starve_q < 4'(STARVE)) || !pf_req_i);

    // NOTE: every next-state signal gets its hold value before the case
    // statement, so no path through the block can leave one unassigned and
    // infer a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        drop_d   = drop_q;
        m_req_d  = m_req_q;
        m_we_d   = m_we_q;
        m_adr_d  = m_adr_q;
        m_dtw_d  = m_dtw_q;
        pf_ack_d = 1'b0;
        xu_ack_d = 1'b0;
        pf_dtr_d = pf_dtr_q;
        xu_dtr_d = xu_dtr_q;

        case (state_q)
            S_IDLE: begin
                if (pf_req_i || xu_req_i) begin
                    state_d = S_BUSY;
                    m_req_d = 1'b1;
                    if (grant_xu) begin
                        owner_d = OWN_XU;
                        m_adr_d = xu_adr_i;
                        m_we_d  = xu_we_i;
                        m_dtw_d = xu_dtw_i;
                        // Only XU grants that bypass a waiting prefetch count.
                        if (pf_req_i) begin
                            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
                        end else begin
                            starve_d = 4'd0;
                        end
                    end else begin
                        owner_d  = OWN_PF;
                        m_adr_d  = pf_adr_i;
                        m_we_d   = 1'b0;
                        m_dtw_d  = '0;
                        starve_d = 4'd0;
                    end
                end
            end

            S_BUSY: begin
                if ((owner_q == OWN_PF) && pf_flush_i) begin
                    drop_d = 1'b1;
                end
                if (m_ack_i) begin
                    state_d = S_TURN;
                    owner_d = OWN_NONE;
                    m_req_d = 1'b0;
                    drop_d  = 1'b0;
                    if (owner_q == OWN_XU) begin
                        xu_ack_d = 1'b1;
                        if (!m_we_q) begin
                            xu_dtr_d = m_dtr_i;
                        end
                    end else if (!(drop_q || pf_flush_i)) begin
                        // A flush on the m_ack cycle itself also drops the data.
                        pf_ack_d = 1'b1;
                        pf_dtr_d = m_dtr_i;
                    end
                end
            end

            S_TURN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                m_req_d = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    // NOTE: reset is asynchronous so m_req drops the moment rst rises, even
    // mid-transaction; non-blocking assignments keep every register sampling
    // the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= 4'd0;
            drop_q   <= 1'b0;
            m_req_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_adr_q  <= '0;
            m_dtw_q  <= '0;
            pf_ack_q <= 1'b0;
            xu_ack_q <= 1'b0;
            pf_dtr_q <= '0;
            xu_dtr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
            m_req_q  <= m_req_d;
            m_we_q   <= m_we_d;
            m_adr_q  <= m_adr_d;
            m_dtw_q  <= m_dtw_d;
            pf_ack_q <= pf_ack_d;
            xu_ack_q <= xu_ack_d;
            pf_dtr_q <= pf_dtr_d;
            xu_dtr_q <= xu_dtr_d;
        end
    end

    assign m_req_o  = m_req_q;
    assign m_we_o   = m_we_q;
    assign m_adr_o  = m_adr_q;
    assign m_dtw_o  = m_dtw_q;
    assign pf_ack_o = pf_ack_q;
    assign xu_ack_o = xu_ack_q;
    assign pf_dtr_o = pf_dtr_q;
    assign xu_dtr_o = xu_dtr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by randomized rounds. The reference model works
// at the transaction level: it applies the grant rule to the pending
// requests, tracks the anti-starvation count as an integer, and predicts the
// fields of each memory request, the completion pulse and the held read data.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW     = 20;
    localparam int DW     = 16;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pf_req, pf_ack, pf_flush;
    logic [AW-1:0] pf_adr;
    logic [DW-1:0] pf_dtr;
    logic          xu_req, xu_we, xu_ack;
    logic [AW-1:0] xu_adr;
    logic [DW-1:0] xu_dtw, xu_dtr;
    logic          m_req, m_we, m_ack;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dtw, m_dtr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            starve_m;
    logic [DW-1:0] exp_pf_dtr;
    logic [DW-1:0] exp_xu_dtr;
    logic          obs_xu_grant;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk        (clk),
        .rst        (rst),
        .pf_req_i   (pf_req),
        .pf_adr_i   (pf_adr),
        .pf_ack_o   (pf_ack),
        .pf_dtr_o   (pf_dtr),
        .pf_flush_i (pf_flush),
        .xu_req_i   (xu_req),
        .xu_we_i    (xu_we),
        .xu_adr_i   (xu_adr),
        .xu_dtw_i   (xu_dtw),
        .xu_ack_o   (xu_ack),
        .xu_dtr_o   (xu_dtr),
        .m_req_o    (m_req),
        .m_we_o     (m_we),
        .m_adr_o    (m_adr),
        .m_dtw_o    (m_dtw),
        .m_ack_i    (m_ack),
        .m_dtr_i    (m_dtr)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_pf();
        pf_req = 1'b1;
        pf_adr = AW'($urandom);
    endtask

    task automatic new_xu();
        xu_req = 1'b1;
        xu_we  = 1'($urandom);
        xu_adr = AW'($urandom);
        xu_dtw = DW'($urandom);
    endtask

    // One complete access, entered and left on an IDLE falling edge.
    //   lat     : busy cycles before m_ack is raised
    //   fmode   : 0 none, 1 flush pulse in busy cycle fk, 2 flush with m_ack,
    //             3 flush during the grant (IDLE) cycle
    //   readv   : winner posts a new request during the TURN cycle
    //   late_xu : XU raises a request while another access is busy
    task automatic do_round(input int lat, input int fmode, input int fk,
                            input logic [DW-1:0] rdata, input bit readv, input bit late_xu);
        bit            g_xu;
        bit            dropped;
        int            fm;
        logic [AW-1:0] e_adr;
        logic          e_we;
        logic [DW-1:0] e_dtw;

        fm = fmode;
        if (fm == 1 && fk >= lat) fm = 0;

        check("idle_mreq", 32'(m_req), 32'd0);

        g_xu = xu_req && (starve_m < STARVE || !pf_req);
        if (g_xu) begin
            e_adr = xu_adr;
            e_we  = xu_we;
            e_dtw = xu_dtw;
            starve_m = pf_req ? ((starve_m < 15) ? starve_m + 1 : 15) : 0;
        end else begin
            e_adr = pf_adr;
            e_we  = 1'b0;
            e_dtw = '0;
            starve_m = 0;
        end

        pf_flush = (fm == 3);
        @(negedge clk);
        pf_flush = 1'b0;
        check("grant_mreq", 32'(m_req), 32'd1);
        check("grant_madr", 32'(m_adr), 32'(e_adr));
        check("grant_mwe",  32'(m_we),  32'(e_we));
        if (g_xu) check("grant_mdtw", 32'(m_dtw), 32'(e_dtw));
        check("busy_acks", 32'({pf_ack, xu_ack}), 32'd0);
        if (late_xu && !xu_req) new_xu();

        for (int k = 0; k < lat; k++) begin
            pf_flush = (fm == 1 && k == fk);
            @(negedge clk);
            pf_flush = 1'b0;
            check("busy_mreq", 32'(m_req), 32'd1);
            check("busy_madr", 32'(m_adr), 32'(e_adr));
        end

        m_ack    = 1'b1;
        m_dtr    = rdata;
        pf_flush = (fm == 2);
        @(negedge clk);
        m_ack    = 1'b0;
        pf_flush = 1'b0;
        m_dtr    = DW'($urandom);

        dropped = !g_xu && (fm == 1 || fm == 2);
        if (g_xu && !e_we) exp_xu_dtr = rdata;
        if (!g_xu && !dropped) exp_pf_dtr = rdata;

        obs_xu_grant = xu_ack;
        check("done_mreq",  32'(m_req),  32'd0);
        check("done_pfack", 32'(pf_ack), 32'(!g_xu && !dropped));
        check("done_xuack", 32'(xu_ack), 32'(g_xu));
        check("done_pfdtr", 32'(pf_dtr), 32'(exp_pf_dtr));
        check("done_xudtr", 32'(xu_dtr), 32'(exp_xu_dtr));

        if (g_xu) begin
            xu_req = 1'b0;
            if (readv) new_xu();
        end else begin
            pf_req = 1'b0;
            if (readv) new_pf();
        end

        @(negedge clk);
        check("turn_acks", 32'({pf_ack, xu_ack}), 32'd0);
        check("turn_mreq", 32'(m_req), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && (pf_req || xu_req); i++) begin
            do_round(1, 0, 0, DW'($urandom), 1'b0, 1'b0);
        end
    endtask

    bit exp_order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        pf_req = 1'b0; pf_adr = '0; pf_flush = 1'b0;
        xu_req = 1'b0; xu_we = 1'b0; xu_adr = '0; xu_dtw = '0;
        m_ack = 1'b0; m_dtr = '0;
        starve_m = 0; exp_pf_dtr = '0; exp_xu_dtr = '0; obs_xu_grant = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_mreq",  32'(m_req),  32'd0);
        check("rst_mwe",   32'(m_we),   32'd0);
        check("rst_madr",  32'(m_adr),  32'd0);
        check("rst_mdtw",  32'(m_dtw),  32'd0);
        check("rst_acks",  32'({pf_ack, xu_ack}), 32'd0);
        check("rst_pfdtr", 32'(pf_dtr), 32'd0);
        check("rst_xudtr", 32'(xu_dtr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single prefetch read
        pf_req = 1'b1; pf_adr = 20'h00010;
        do_round(2, 0, 0, 16'hBEEF, 1'b0, 1'b0);

        // XU write leaves xu_dtr alone
        xu_req = 1'b1; xu_we = 1'b1; xu_adr = 20'h0ABCD; xu_dtw = 16'h1234;
        do_round(1, 0, 0, 16'h9999, 1'b0, 1'b0);

        // Starvation: both requesters continuously busy
        pf_req = 1'b1; pf_adr = 20'h00200;
        xu_req = 1'b1; xu_we = 1'b0; xu_adr = 20'h00300; xu_dtw = 16'h0;
        for (int i = 0; i < 6; i++) begin
            do_round(1, 0, 0, DW'($urandom), 1'b1, 1'b0);
            check($sformatf("starve_order%0d", i), 32'(obs_xu_grant), 32'(exp_order[i]));
        end
        pf_req = 1'b0;
        drain();
        xu_req = 1'b0;

        // Flush two cycles before m_ack, then a normal prefetch
        pf_req = 1'b1; pf_adr = 20'h00020;
        do_round(3, 1, 1, 16'hDEAD, 1'b0, 1'b0);
        pf_req = 1'b1; pf_adr = 20'h00100;
        do_round(1, 0, 0, 16'h5A5A, 1'b0, 1'b0);

        // Flush coincident with m_ack; XU arrives mid-fetch and is served next
        pf_req = 1'b1; pf_adr = 20'h00040;
        do_round(2, 2, 0, 16'hCAFE, 1'b0, 1'b1);
        do_round(0, 0, 0, 16'h0F0F, 1'b0, 1'b0);

        // Asynchronous reset during BUSY
        xu_req = 1'b1; xu_we = 1'b1; xu_adr = 20'h01111; xu_dtw = 16'hAAAA;
        @(negedge clk);
        check("arst_pre_mreq", 32'(m_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_mreq", 32'(m_req), 32'd0);
        check("arst_mwe",  32'(m_we),  32'd0);
        check("arst_acks", 32'({pf_ack, xu_ack}), 32'd0);
        @(negedge clk);
        xu_req = 1'b0; xu_we = 1'b0;
        rst = 1'b0;
        starve_m = 0; exp_pf_dtr = '0; exp_xu_dtr = '0;
        check("arst_pfdtr", 32'(pf_dtr), 32'd0);
        check("arst_xudtr", 32'(xu_dtr), 32'd0);
        pf_req = 1'b1; pf_adr = 20'h00055;
        do_round(1, 0, 0, 16'h1357, 1'b0, 1'b0);

        // Randomized rounds
        for (int r = 0; r < 150; r++) begin
            if (!pf_req && $urandom_range(1, 0) == 1) new_pf();
            if (!xu_req && $urandom_range(1, 0) == 1) new_xu();
            if (!pf_req && !xu_req) new_pf();
            do_round(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)), DW'($urandom),
                     1'($urandom), $urandom_range(3, 0) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
